// File: rtl/compositor_pkg.sv
// Shared constants and game layer indices for the VGA object compositor.
package compositor_pkg;

    localparam int         NUM_LAYERS_DEF = 4;
    localparam int         RGB_W_DEF      = 8;
    localparam logic [7:0] BG_COLOR_DEF   = 8'h00;

    // Lower index wins, so the player is always drawn on top.
    typedef enum logic [1:0] {
        PLAYER = 2'd0,
        BOMB   = 2'd1,
        ENEMY  = 2'd2,
        WALL   = 2'd3
    } layer_idx_e;

endpackage

// File: rtl/compositor_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and which index wins.
module compositor_prio_enc #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scanning from the top down lets the lowest set bit overwrite every higher one.
    always_comb begin
        found = |req;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor with a frame-synchronous layer-enable mask.
// Define LAYER_COMPOSITOR_COLLISION_EN to build per-frame collision reporting against layer 0.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int               NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int               RGB_W      = RGB_W_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR   = RGB_W'(BG_COLOR_DEF),
    localparam int              SEL_W      = $clog2(NUM_LAYERS)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic [NUM_LAYERS-1:0] DR,
    input  logic [RGB_W-1:0]      RGB [NUM_LAYERS],
    input  logic                  mask_wr,
    input  logic [NUM_LAYERS-1:0] mask_in,
    output logic                  drawingRequest,
    output logic [RGB_W-1:0]      RGBout,
    output logic [SEL_W-1:0]      layer_sel,
    output logic [NUM_LAYERS-1:0] collision_out,
    output logic                  collision_valid
);

    logic [NUM_LAYERS-1:0] pending_mask;
    logic [NUM_LAYERS-1:0] active_mask;
    logic [NUM_LAYERS-1:0] frame_mask;
    logic [NUM_LAYERS-1:0] eff;
    logic                  win_found;
    logic [SEL_W-1:0]      win_idx;

    // The first pixel of a frame already sees the mask that frame will use,
    // including one written in that very cycle.
    always_comb begin
        frame_mask = active_mask;
        if (startOfFrame) begin
            frame_mask = mask_wr ? mask_in : pending_mask;
        end
    end

    assign eff = DR & frame_mask;

    compositor_prio_enc #(
        .N(NUM_LAYERS)
    ) u_prio_enc (
        .req   (eff),
        .found (win_found),
        .index (win_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pending_mask <= '1;
            active_mask  <= '1;
        end else begin
            if (mask_wr) begin
                pending_mask <= mask_in;
            end
            if (startOfFrame) begin
                active_mask <= frame_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            RGBout         <= BG_COLOR;
            layer_sel      <= '0;
        end else if (win_found) begin
            drawingRequest <= 1'b1;
            RGBout         <= RGB[win_idx];
            layer_sel      <= win_idx;
        end else begin
            drawingRequest <= 1'b0;
            RGBout         <= BG_COLOR;
            layer_sel      <= '0;
        end
    end

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    logic [NUM_LAYERS-1:0] hit;
    logic [NUM_LAYERS-1:0] coll_acc;

    // Layer 0 never collides with itself, so its hit bit is forced low.
    assign hit = {NUM_LAYERS{eff[0]}} & {eff[NUM_LAYERS-1:1], 1'b0};

    always_ff @(posedge clk) begin
        if (!resetN) begin
            coll_acc        <= '0;
            collision_out   <= '0;
            collision_valid <= 1'b0;
        end else if (startOfFrame) begin
            collision_out   <= coll_acc;
            coll_acc        <= hit;
            collision_valid <= 1'b1;
        end else begin
            coll_acc        <= coll_acc | hit;
            collision_valid <= 1'b0;
        end
    end
`else
    assign collision_out   = '0;
    assign collision_valid = 1'b0;
`endif

endmodule
